// File: rtl/mprj_xfer_arb.sv
// Round-robin arbiter granting the serial io loader to the management core (req[0]) or housekeeping SPI (req[1]).
// Optional transfer watchdog enabled by defining MPRJ_XFER_TIMEOUT_EN.
module mprj_xfer_arb #(
    parameter int                   TIMEOUT_W = 32'sd12,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 12'd2000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic [1:0] err,
    output logic       src_sel,
    output logic       xfer_start,
    input  logic       loader_busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_ACK       = 3'd4
    } state_t;

    state_t     r_state;
    logic       r_owner;
    logic       r_last;
    logic       r_xfer_start;
    logic [1:0] r_gnt;
    logic [1:0] r_done;
    logic [1:0] r_err;

    logic       w_pick;
    logic       w_arb_go;
    logic       w_expired;

    function automatic logic [1:0] f_onehot(input logic idx);
        f_onehot = idx ? 2'b10 : 2'b01;
    endfunction

    // A busy loader in IDLE belongs to someone else's transfer, so hold off arbitration.
    assign w_arb_go = (req != 2'b00) && !loader_busy;

    // Round-robin pick: on a tie the requester not granted last time wins.
    always_comb begin
        w_pick = 1'b0;
        case (req)
            2'b01:   w_pick = 1'b0;
            2'b10:   w_pick = 1'b1;
            2'b11:   w_pick = ~r_last;
            default: w_pick = 1'b0;
        endcase
    end

`ifdef MPRJ_XFER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_wdog;
    logic [TIMEOUT_W-1:0] w_wdog_next;
    logic                 w_waiting;

    assign w_waiting   = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
    assign w_wdog_next = r_wdog + TIMEOUT_W'(1'b1);
    assign w_expired   = w_waiting && (w_wdog_next == TIMEOUT);

    // Watchdog: cleared on the way into WAIT_BUSY, counts every cycle spent waiting on the loader.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wdog <= {TIMEOUT_W{1'b0}};
        end else if (r_state == S_START) begin
            r_wdog <= {TIMEOUT_W{1'b0}};
        end else if (w_waiting) begin
            r_wdog <= w_wdog_next;
        end else begin
            r_wdog <= r_wdog;
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT;
    assign w_expired        = 1'b0;
`endif

    // Transfer FSM; all outputs are registered and change only on state transitions.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last       <= 1'b1;
            r_gnt        <= 2'b00;
            r_done       <= 2'b00;
            r_err        <= 2'b00;
            r_xfer_start <= 1'b0;
        end else begin
            r_xfer_start <= 1'b0;
            r_done       <= 2'b00;
            r_err        <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (w_arb_go) begin
                        r_state      <= S_START;
                        r_owner      <= w_pick;
                        r_gnt        <= f_onehot(w_pick);
                        r_xfer_start <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_START: begin
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (w_expired) begin
                        r_state <= S_ACK;
                        r_done  <= f_onehot(r_owner);
                        r_err   <= f_onehot(r_owner);
                    end else if (loader_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else begin
                        r_state <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_DONE: begin
                    if (!loader_busy) begin
                        r_state <= S_ACK;
                        r_done  <= f_onehot(r_owner);
                    end else if (w_expired) begin
                        r_state <= S_ACK;
                        r_done  <= f_onehot(r_owner);
                        r_err   <= f_onehot(r_owner);
                    end else begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    r_gnt   <= 2'b00;
                    r_last  <= r_owner;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= 2'b00;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign done       = r_done;
    assign err        = r_err;
    assign src_sel    = r_owner;
    assign xfer_start = r_xfer_start;

endmodule

// File: doc/mprj_xfer_arb.md
MPRJ_XFER_ARB -- requirements
Module: mprj_xfer_arb

Interface
REQ-001 The block SHALL have parameter TIMEOUT_W, default 12, meaning the watchdog counter width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 12'd2000, meaning the maximum clk cycles allowed from entering WAIT_BUSY until loader_busy falls.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock, rising-edge active.
REQ-004 The block SHALL have port resetn, input, 1 bit: the reset, asynchronous, active-low.
REQ-005 The block SHALL have port req, input, 2 bits: a level request per requester (bit 0 management core, bit 1 housekeeping SPI).
REQ-006 The block SHALL have port gnt, output, 2 bits: one-hot grant, held from START through ACK.
REQ-007 The block SHALL have port done, output, 2 bits: a one-cycle completion pulse to the owning requester.
REQ-008 The block SHALL have port err, output, 2 bits: a one-cycle timeout flag, coincident with done.
REQ-009 The block SHALL have port src_sel, output, 1 bit: the index of the current or last owner, which steers the io_ctrl write source.
REQ-010 The block SHALL have port xfer_start, output, 1 bit: a one-cycle pulse to the serial loader transfer trigger.
REQ-011 The block SHALL have port loader_busy, input, 1 bit: the serial loader busy status.

Function
REQ-012 The FSM SHALL have states IDLE, START, WAIT_BUSY, WAIT_DONE and ACK, and all outputs SHALL decode only from registered state and owner.
REQ-013 In IDLE with req!=0, the block SHALL select an owner and go to START on the next edge; with req==0 it SHALL stay in IDLE.
REQ-014 The arbitration SHALL be round-robin: a single requester wins, and when both request, the requester not granted last wins.
REQ-015 The last-grant register SHALL reset to 1, so requester 0 wins the first tie.
REQ-016 In START, xfer_start SHALL be 1 for exactly one cycle and gnt[owner] SHALL be 1; the FSM SHALL then go to WAIT_BUSY.
REQ-017 In WAIT_BUSY, the FSM SHALL go to WAIT_DONE when loader_busy==1.
REQ-018 In WAIT_DONE, the FSM SHALL go to ACK when loader_busy==0.
REQ-019 In ACK, done[owner] SHALL be 1 for one cycle, the last-grant register SHALL update to owner, and the FSM SHALL then return to IDLE.
REQ-020 Latency from req sampled in IDLE to xfer_start SHALL be 1 cycle, and at least one IDLE cycle SHALL separate consecutive grants.
REQ-021 src_sel SHALL update on the IDLE->START edge and SHALL hold its value through IDLE.
REQ-022 A requester dropping req after grant SHALL NOT abort the transfer; done SHALL still pulse.
REQ-023 req changes while not in IDLE SHALL be ignored; a req held through ACK SHALL be re-arbitrated in the following IDLE.
REQ-024 loader_busy already 1 in IDLE (a foreign transfer) SHALL block arbitration until it falls.
REQ-025 gnt, done and err SHALL be one-hot or zero at all times.

Reset
REQ-026 Asserting resetn low at any time, including mid-transfer, SHALL asynchronously force state IDLE, gnt=0, done=0, err=0, xfer_start=0, src_sel=0, last-grant=1 and watchdog=0.
REQ-027 Release of resetn SHALL be synchronous to clk, with the first arbitration occurring no earlier than the first edge after release.

Configuration
REQ-028 With macro MPRJ_XFER_TIMEOUT_EN defined, a TIMEOUT_W-bit counter SHALL clear on entering WAIT_BUSY and increment each cycle in WAIT_BUSY and WAIT_DONE.
REQ-029 With MPRJ_XFER_TIMEOUT_EN defined, the count reaching TIMEOUT SHALL force ACK with err[owner]=1 and done[owner]=1.
REQ-030 With MPRJ_XFER_TIMEOUT_EN undefined, no counter SHALL exist, err SHALL be tied to 0, and WAIT_BUSY/WAIT_DONE SHALL wait indefinitely.

Verification
REQ-031 The bench SHALL cover: req=01, loader model busy 2 cycles after xfer_start for 340 cycles -> gnt=01, one xfer_start, done=01 once, err=00, src_sel=0.
REQ-032 The bench SHALL cover: req=11 held across 3 transfers from reset -> grant order 0,1,0, with each done pulse preceding the next xfer_start by at least 2 cycles.
REQ-033 The bench SHALL cover: req=10 dropped 1 cycle after gnt -> transfer completes and done=10 pulses.
REQ-034 The bench SHALL cover: resetn low during WAIT_DONE, then high -> all outputs 0 immediately, IDLE, and the next tie is granted to 0.
REQ-035 The bench SHALL cover: MPRJ_XFER_TIMEOUT_EN defined, TIMEOUT=16, loader_busy stuck 1 -> done=err=01 exactly 16 cycles after WAIT_BUSY entry.
REQ-036 The bench SHALL cover: loader_busy=1 in IDLE with req=01 -> no gnt until busy falls, then gnt=01 on the next edge.
